// File: rtl/joy_dir_filter.sv
// ---------------------------------------------------------------------------
// joy_dir_filter
//   Multi-player joystick direction filter. For each player the raw
//   direction nibble passes through a cabinet-rotation remap, a one-stage
//   input sync, a per-bit debouncer, and then one of four direction
//   arbitration modes. Outputs are registered.
//
// Ports
//   clk        system clock
//   i_reset_n  synchronous active-low reset
//   i_ce       debounce sample enable
//   i_mode     0=8-way SOCD-clean, 1=4-way last-pressed,
//              2=4-way last-pressed with fallback, 3=4-way first-held
//   i_rot      0=none, 1=90 CW, 2=180, 3=90 CCW
//   i_in_dir   raw directions, player p at [4p+3:4p] = {up,down,left,right}
//   o_out_dir  filtered directions, same layout
//   o_changed  per-player one-clock strobe when that player's output changes
// ---------------------------------------------------------------------------
module joy_dir_filter #(
  parameter int PLAYERS  = 2,
  parameter int DEBOUNCE = 4,
  parameter int CW       = $clog2(DEBOUNCE + 1)
) (
  input  logic                   clk,
  input  logic                   i_reset_n,
  input  logic                   i_ce,
  input  logic [1:0]             i_mode,
  input  logic [1:0]             i_rot,
  input  logic [4*PLAYERS-1:0]   i_in_dir,
  output logic [4*PLAYERS-1:0]   o_out_dir,
  output logic [PLAYERS-1:0]     o_changed
);

  localparam logic [CW-1:0] LP_CNT_MAX = CW'(DEBOUNCE - 1);

  // One-hot of the highest-priority set bit: up > down > left > right.
  function automatic logic [3:0] f_pri(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    if (v[3])      r = 4'b1000;
    else if (v[2]) r = 4'b0100;
    else if (v[1]) r = 4'b0010;
    else if (v[0]) r = 4'b0001;
    return r;
  endfunction

  // Mode is shared by all players; a change is seen for exactly one clock.
  logic [1:0] r_mode;
  logic       w_mode_chg;

  assign w_mode_chg = (i_mode != r_mode);

  always_ff @(posedge clk) begin
    r_mode <= i_mode;
  end

  genvar gi;
  generate
    for (gi = 0; gi < PLAYERS; gi++) begin : g_player
      logic [3:0]    w_raw;
      logic [3:0]    w_rot;
      logic [3:0]    r_sync;
      logic [3:0]    r_stable;
      logic [3:0]    r_prev;
      logic [3:0]    r_mask;
      logic [3:0]    r_out;
      logic          r_chg;
      logic [CW-1:0] r_cnt [4];
      logic [3:0]    w_rise;
      logic [3:0]    w_mask_next;
      logic [3:0]    w_out_next;

      assign w_raw = i_in_dir[4*gi +: 4];

      // Cabinet rotation, applied before the sync stage.
      always_comb begin
        w_rot = w_raw;
        case (i_rot)
          2'd1:    w_rot = {w_raw[1], w_raw[0], w_raw[2], w_raw[3]};
          2'd2:    w_rot = {w_raw[2], w_raw[3], w_raw[0], w_raw[1]};
          2'd3:    w_rot = {w_raw[0], w_raw[1], w_raw[3], w_raw[2]};
          default: w_rot = w_raw;
        endcase
      end

      // Sync and per-bit debounce. A mismatch must persist for DEBOUNCE
      // consecutive ce ticks; any agreeing tick restarts the count.
      always_ff @(posedge clk) begin
        if (!i_reset_n) begin
          r_sync   <= '0;
          r_stable <= '0;
          for (int b = 0; b < 4; b++) r_cnt[b] <= '0;
        end else begin
          r_sync <= w_rot;
          if (i_ce) begin
            for (int b = 0; b < 4; b++) begin
              if (r_sync[b] == r_stable[b]) begin
                r_cnt[b] <= '0;
              end else if (r_cnt[b] == LP_CNT_MAX) begin
                r_stable[b] <= r_sync[b];
                r_cnt[b]    <= '0;
              end else begin
                r_cnt[b] <= r_cnt[b] + 1'b1;
              end
            end
          end
        end
      end

      assign w_rise = r_stable & ~r_prev;

      // Arbitration. The output uses the next mask so a new press is
      // visible on the same edge that loads the mask.
      always_comb begin
        w_mask_next = r_mask;
        w_out_next  = 4'b0000;
        if (w_mode_chg) begin
          w_mask_next = 4'b0000;
          w_out_next  = 4'b0000;
        end else begin
          case (r_mode)
            2'd0: begin
              w_mask_next = 4'b0000;
              w_out_next  = r_stable;
              if (r_stable[3] && r_stable[2]) w_out_next[3:2] = 2'b00;
              if (r_stable[1] && r_stable[0]) w_out_next[1:0] = 2'b00;
            end
            2'd1: begin
              if (|w_rise) w_mask_next = f_pri(w_rise);
              w_out_next = r_stable & w_mask_next;
            end
            2'd2: begin
              if (|w_rise)
                w_mask_next = f_pri(w_rise);
              else if (((r_stable & r_mask) == 4'b0000) && (r_stable != 4'b0000))
                w_mask_next = f_pri(r_stable);
              w_out_next = r_stable & w_mask_next;
            end
            default: begin
              if ((r_stable & r_mask) == 4'b0000) w_mask_next = f_pri(r_stable);
              w_out_next = r_stable & w_mask_next;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (!i_reset_n) begin
          r_prev <= '0;
          r_mask <= '0;
          r_out  <= '0;
          r_chg  <= 1'b0;
        end else begin
          r_prev <= r_stable;
          r_mask <= w_mask_next;
          r_out  <= w_out_next;
          r_chg  <= (w_out_next != r_out);
        end
      end

      assign o_out_dir[4*gi +: 4] = r_out;
      assign o_changed[gi]        = r_chg;
    end
  endgenerate

endmodule

// File: tb/tb_joy_dir_filter.sv
// ---------------------------------------------------------------------------
// tb_joy_dir_filter
//   Directed self-checking bench for joy_dir_filter with PLAYERS=2 and
//   DEBOUNCE=4. Inputs are driven 1 time unit after the rising edge and
//   outputs are sampled at the same point, so "after edge N" below means
//   the value registered by edge N.
// ---------------------------------------------------------------------------
module tb_joy_dir_filter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic [1:0] mode;
  logic [1:0] rot;
  logic [7:0] in_dir;
  logic [7:0] out_dir;
  logic [1:0] changed;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  joy_dir_filter #(
    .PLAYERS (2),
    .DEBOUNCE(4)
  ) dut (
    .clk      (clk),
    .i_reset_n(reset_n),
    .i_ce     (ce),
    .i_mode   (mode),
    .i_rot    (rot),
    .i_in_dir (in_dir),
    .o_out_dir(out_dir),
    .o_changed(changed)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    mode    = m;
    rot     = 2'd0;
    in_dir  = 8'h00;
    ce      = 1'b1;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(2'd1);
    n_checks++;
    if (out_dir !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_out: got %h expected %h", out_dir, 8'h00);
    end else $display("ok   reset_out = %h", out_dir);
    n_checks++;
    if (changed !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_changed: got %b expected %b", changed, 2'b00);
    end else $display("ok   reset_changed = %b", changed);
  endtask

  // Raw change presented for the first edge after reset release reaches
  // the output at the sixth edge (1 sync + 4 debounce + 1 output).
  task automatic test_latency;
    do_reset(2'd1);
    in_dir = 8'h08;
    tick(5);
    n_checks++;
    if (out_dir !== 8'h00) begin
      n_errors++;
      $display("FAIL latency_early: got %h expected %h", out_dir, 8'h00);
    end else $display("ok   latency_early = %h", out_dir);
    tick(1);
    n_checks++;
    if (out_dir !== 8'h08) begin
      n_errors++;
      $display("FAIL latency_out: got %h expected %h", out_dir, 8'h08);
    end else $display("ok   latency_out = %h", out_dir);
    n_checks++;
    if (changed !== 2'b01) begin
      n_errors++;
      $display("FAIL latency_strobe: got %b expected %b", changed, 2'b01);
    end else $display("ok   latency_strobe = %b", changed);
    tick(1);
    n_checks++;
    if (changed !== 2'b00 || out_dir !== 8'h08) begin
      n_errors++;
      $display("FAIL latency_strobe_end: got %b/%h expected 00/08", changed, out_dir);
    end else $display("ok   latency_strobe_end = %b/%h", changed, out_dir);
    reset_n = 1'b0;
    tick(1);
    n_checks++;
    if (out_dir !== 8'h00 || changed !== 2'b00) begin
      n_errors++;
      $display("FAIL latency_reset: got %h/%b expected 00/00", out_dir, changed);
    end else $display("ok   latency_reset = %h/%b", out_dir, changed);
    reset_n = 1'b1;
  endtask

  task automatic test_glitch;
    do_reset(2'd1);
    // 3 clocks wide with ce high -> 3 debounce ticks, rejected.
    in_dir = 8'h02;
    tick(3);
    in_dir = 8'h00;
    tick(10);
    n_checks++;
    if (out_dir !== 8'h00) begin
      n_errors++;
      $display("FAIL glitch_3tick: got %h expected %h", out_dir, 8'h00);
    end else $display("ok   glitch_3tick = %h", out_dir);
    // 6 clocks wide with ce on alternate clocks -> 3 debounce ticks.
    for (int k = 0; k < 12; k++) begin
      in_dir = (k < 6) ? 8'h02 : 8'h00;
      ce     = ((k % 2) == 0);
      tick(1);
    end
    ce = 1'b1;
    tick(8);
    n_checks++;
    if (out_dir !== 8'h00) begin
      n_errors++;
      $display("FAIL glitch_ce_3tick: got %h expected %h", out_dir, 8'h00);
    end else $display("ok   glitch_ce_3tick = %h", out_dir);
    // 4 clocks wide -> accepted; visible 2 edges after the raw release.
    in_dir = 8'h02;
    tick(4);
    in_dir = 8'h00;
    tick(2);
    n_checks++;
    if (out_dir !== 8'h02) begin
      n_errors++;
      $display("FAIL glitch_4tick: got %h expected %h", out_dir, 8'h02);
    end else $display("ok   glitch_4tick = %h", out_dir);
    tick(8);
  endtask

  task automatic test_last_pressed(input logic [1:0] m, input logic [7:0] exp_release);
    do_reset(m);
    in_dir = 8'h01;
    tick(8);
    n_checks++;
    if (out_dir !== 8'h01) begin
      n_errors++;
      $display("FAIL mode%0d_right: got %h expected %h", m, out_dir, 8'h01);
    end else $display("ok   mode%0d_right = %h", m, out_dir);
    in_dir = 8'h09;
    tick(8);
    n_checks++;
    if (out_dir !== 8'h08) begin
      n_errors++;
      $display("FAIL mode%0d_add_up: got %h expected %h", m, out_dir, 8'h08);
    end else $display("ok   mode%0d_add_up = %h", m, out_dir);
    in_dir = 8'h01;
    tick(8);
    n_checks++;
    if (out_dir !== exp_release) begin
      n_errors++;
      $display("FAIL mode%0d_release_up: got %h expected %h", m, out_dir, exp_release);
    end else $display("ok   mode%0d_release_up = %h", m, out_dir);
  endtask

  task automatic test_first_held;
    do_reset(2'd3);
    in_dir = 8'h02;
    tick(8);
    n_checks++;
    if (out_dir !== 8'h02) begin
      n_errors++;
      $display("FAIL mode3_left: got %h expected %h", out_dir, 8'h02);
    end else $display("ok   mode3_left = %h", out_dir);
    in_dir = 8'h06;
    tick(8);
    n_checks++;
    if (out_dir !== 8'h02) begin
      n_errors++;
      $display("FAIL mode3_add_down: got %h expected %h", out_dir, 8'h02);
    end else $display("ok   mode3_add_down = %h", out_dir);
    in_dir = 8'h04;
    tick(8);
    n_checks++;
    if (out_dir !== 8'h04) begin
      n_errors++;
      $display("FAIL mode3_release_left: got %h expected %h", out_dir, 8'h04);
    end else $display("ok   mode3_release_left = %h", out_dir);
    in_dir = 8'h00;
    tick(8);
    in_dir = 8'h09;
    tick(8);
    n_checks++;
    if (out_dir !== 8'h08) begin
      n_errors++;
      $display("FAIL mode3_priority: got %h expected %h", out_dir, 8'h08);
    end else $display("ok   mode3_priority = %h", out_dir);
  endtask

  task automatic test_socd_rotation;
    logic [1:0] rots [5];
    logic [7:0] raws [5];
    logic [7:0] exps [5];
    rots = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
    raws = '{8'h0C, 8'h09, 8'h08, 8'h08, 8'h02};
    exps = '{8'h00, 8'h09, 8'h01, 8'h02, 8'h01};
    do_reset(2'd0);
    for (int i = 0; i < 5; i++) begin
      rot    = rots[i];
      in_dir = raws[i];
      tick(8);
      n_checks++;
      if (out_dir !== exps[i]) begin
        n_errors++;
        $display("FAIL mode0_vec%0d rot=%0d raw=%h: got %h expected %h",
                 i, rots[i], raws[i], out_dir, exps[i]);
      end else $display("ok   mode0_vec%0d rot=%0d raw=%h -> %h", i, rots[i], raws[i], out_dir);
    end
  endtask

  task automatic test_players_mode_switch;
    bit found;
    do_reset(2'd1);
    in_dir = 8'h18;
    tick(8);
    n_checks++;
    if (out_dir !== 8'h18) begin
      n_errors++;
      $display("FAIL players_init: got %h expected %h", out_dir, 8'h18);
    end else $display("ok   players_init = %h", out_dir);
    // Only player 0 changes; player 1 must not strobe.
    in_dir = 8'h14;
    found  = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick(1);
      if (changed !== 2'b00) found = 1'b1;
    end
    n_checks++;
    if (!found || changed !== 2'b01 || out_dir !== 8'h14) begin
      n_errors++;
      $display("FAIL players_crosstalk: got %b/%h expected 01/14 (seen=%0d)",
               changed, out_dir, found);
    end else $display("ok   players_crosstalk = %b/%h", changed, out_dir);
    in_dir = 8'h40;
    tick(8);
    n_checks++;
    if (out_dir !== 8'h40) begin
      n_errors++;
      $display("FAIL switch_pre: got %h expected %h", out_dir, 8'h40);
    end else $display("ok   switch_pre = %h", out_dir);
    mode = 2'd3;
    tick(1);
    n_checks++;
    if (out_dir !== 8'h00 || changed !== 2'b10) begin
      n_errors++;
      $display("FAIL switch_gap: got %h/%b expected 00/10", out_dir, changed);
    end else $display("ok   switch_gap = %h/%b", out_dir, changed);
    tick(1);
    n_checks++;
    if (out_dir !== 8'h40 || changed !== 2'b10) begin
      n_errors++;
      $display("FAIL switch_post: got %h/%b expected 40/10", out_dir, changed);
    end else $display("ok   switch_post = %h/%b", out_dir, changed);
  endtask

  initial begin
    reset_n = 1'b0;
    ce      = 1'b1;
    mode    = 2'd1;
    rot     = 2'd0;
    in_dir  = 8'h00;
    test_reset();
    test_latency();
    test_glitch();
    test_last_pressed(2'd1, 8'h00);
    test_last_pressed(2'd2, 8'h01);
    test_first_held();
    test_socd_rotation();
    test_players_mode_switch();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/joy_dir_filter.md
Name: joy_dir_filter

Overview:
- Parametrised multi-player joystick direction filter; successor to the single 4-way last-pressed mask used between the input mux and the game core's IN0/IN1 ports.
- Per player, in order: cabinet rotation remap, input sync, per-bit debounce, then one of four selectable direction-arbitration modes.
- Registered direction outputs, plus a one-cycle change strobe per player.

Parameters:
- PLAYERS, 2, number of independent joystick channels.
- DEBOUNCE, 4, consecutive ce ticks a raw bit must differ from its stable value before the stable value flips. Minimum 1.
- CW, $clog2(DEBOUNCE+1), debounce counter width (derived, do not override).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- ce  in  1  debounce sample enable.
- mode  in  2  0=8-way SOCD-clean, 1=4-way last-pressed, 2=4-way last-pressed with fallback, 3=4-way first-held.
- rot  in  2  0=none, 1=90 CW, 2=180, 3=90 CCW.
- in_dir  in  4*PLAYERS  raw directions, active-high; player p at [4p+3:4p], order {up,down,left,right}.
- out_dir  out  4*PLAYERS  filtered directions, same layout.
- changed  out  PLAYERS  one-clk strobe when a player's out_dir changes.

Behaviour:
- Reset (reset_n=0 at a clk edge): out_dir=0, changed=0, sync/stable/prev-stable regs=0, all counters=0, masks=0, mode_r=mode. Reset takes priority over every other event, including mid-debounce and mid-hold.
- Rotation (combinational, before sync):
  - rot=1: up<=left, down<=right, left<=down, right<=up.
  - rot=3: up<=right, down<=left, left<=up, right<=down.
  - rot=2: swap up/down and swap left/right.
- Sync: sync_r <= rotated in_dir every clk.
- Debounce, per bit, only on ce=1 clocks:
  - sync_r==stable: counter <= 0.
  - Otherwise, if counter==DEBOUNCE-1: stable <= sync_r and counter <= 0.
  - Otherwise: counter++.
  - ce=0: counter and stable hold.
  - Any mismatch run shorter than DEBOUNCE ce ticks is fully ignored.
- Arbitration, every clk from stable (S) and prev_S (S registered one clk). rise = S & ~prev_S. Priority among simultaneous bits: up > down > left > right.
  - Mode 0: no mask. Output = S, but up&down both set -> both 0; left&right both set -> both 0.
  - Mode 1: any rise loads mask with the one-hot of the highest-priority rising bit. Output = S & mask. When the masked bit is released, output is 0 even if other bits are still held.
  - Mode 2: as mode 1, plus: if (S & mask)==0 and S!=0 with no rise, mask <= one-hot of the highest-priority held bit.
  - Mode 3: if (S & mask)!=0, mask holds and rises are ignored. Otherwise mask <= one-hot of the highest-priority bit of S (0 if S==0).
- Mode change: mode_r registered each clk. When mode!=mode_r, all masks clear that clk and out_dir is recomputed from the new mode on the next clk. No glitch beyond one clk of 0.
- out_dir registered, one clk after mask/S update. changed[p] = (new out_dir[p] != old out_dir[p]), registered with out_dir.
- Latency, ce tied high: a raw change held steady reaches out_dir DEBOUNCE+2 clk edges after first being presented (1 sync + DEBOUNCE debounce + 1 output), with arbitration folded into the output stage.
- Players are fully independent; no cross-player interaction.

Test Plan:
- Reset/latency: DEBOUNCE=4, ce=1, mode=1, raw p0 up asserted at edge 0 -> out_dir[3]=1 first visible after edge 6; changed[0]=1 for exactly one clk; reset_n=0 at edge 10 -> out_dir=0 on the next edge.
- Glitch rejection: raw left pulse 3 ce ticks wide with DEBOUNCE=4 -> out_dir stays 0. Same pulse with ce toggling every other clk, 3 ce ticks -> still 0. Pulse 4 ce ticks wide -> asserts.
- Mode 1 vs mode 2: hold right, then add up, then release up -> mode 1 out = 0001, 1000, 0000. Mode 2 out = 0001, 1000, 0001.
- Mode 3 and priority: hold left, then add down -> out stays 0010. Release left -> 0100. Simultaneous up+right rise from idle -> 1000.
- Mode 0 SOCD and rotation: raw 1100 -> 0000. Raw 1001 -> 1001. rot=1 with raw up -> out right (0001). rot=3 with raw up -> out left (0010). rot=2 with raw left -> out right.
- Multi-player and mode switch: PLAYERS=2, independent stimuli on p0/p1 -> no crosstalk. Switch mode 1->3 while p1 holds down -> one clk of 0000, then 0100.
